// File: rtl/serial_adder_seq.sv
// Bit-serial LSB-first adder: two half-adder cells plus a registered carry, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that selects a - b (two's complement) at start.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic             c_q, carry_q, busy_q, done_q;
    logic [CW-1:0]    cnt_q;

    logic             ha1_s, ha1_c, ha2_c;
    logic             s_d, c_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Full adder built from two half adders; their carries can never both be 1, so OR suffices.
    assign ha1_s = a_q[0] ^ b_q[0];
    assign ha1_c = a_q[0] & b_q[0];
    assign s_d   = ha1_s ^ c_q;
    assign ha2_c = ha1_s & c_q;
    assign c_d   = ha1_c | ha2_c;
    assign res_d = {s_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: a + ~b + 1, so carry_out=1 means no borrow.
    assign b_load = sub ? ~b_in : b_in;
    assign c_load = sub;
`else
    assign b_load = b_in;
    assign c_load = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_load;
                        c_q     <= c_load;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= res_d;
                        carry_q <= c_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq (WIDTH=8); the subtract cases need SERIAL_ADDER_SUB_EN.
module tb_serial_adder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif
    logic       busy, done, carry_out;
    logic [7:0] sum_out;

    int checks = 0;
    int errors = 0;

    serial_adder_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // One full operation: busy for 8 cycles with outputs held, then a single done with the result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec, input string nm);
        logic [7:0] ps;
        logic       pc;
        @(negedge clk);
        ps = sum_out;
        pc = carry_out;
        start = 1'b1; a_in = a; b_in = b;
        @(posedge clk);
        #1 start = 1'b0; a_in = ~a; b_in = ~b;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum_out !== ps || carry_out !== pc) begin
                errors++;
                $display("FAIL %s busy_phase cyc=%0d busy=%b done=%b sum=%h c=%b want busy=1 done=0 sum=%h c=%b",
                         nm, i, busy, done, sum_out, carry_out, ps, pc);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_strobe done=%b busy=%b want done=1 busy=0", nm, done, busy);
        end
        checks++;
        if (sum_out !== es || carry_out !== ec) begin
            errors++;
            $display("FAIL %s result sum=%h c=%b want sum=%h c=%b", nm, sum_out, carry_out, es, ec);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum_out !== es) begin
            errors++;
            $display("FAIL %s after_done done=%b busy=%b sum=%h want 0 0 %h", nm, done, busy, sum_out, es);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 8'h00 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset busy=%b done=%b sum=%h c=%b want all 0", busy, done, sum_out, carry_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        run_op(8'h35, 8'h4A, 8'h7F, 1'b0, "add_35_4a");
    endtask

    task automatic test_carry();
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
        run_op(8'h80, 8'h80, 8'h00, 1'b1, "add_80_80");
    endtask

    task automatic test_start_while_busy();
        int ndone = 0;
        @(negedge clk);
        start = 1'b1; a_in = 8'h12; b_in = 8'h34;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) begin
                start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if (sum_out !== 8'h46 || carry_out !== 1'b0 || i != 9) begin
                    errors++;
                    $display("FAIL ignore_busy result cyc=%0d sum=%h c=%b want cyc=9 sum=46 c=0",
                             i, sum_out, carry_out);
                end
            end
        end
        checks++;
        if (ndone != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy done_count=%0d busy=%b want 1 0", ndone, busy);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        @(negedge clk);
        start = 1'b1; a_in = 8'h0F; b_in = 8'h01;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                if (first < 0) begin
                    first = i;
                    checks++;
                    if (sum_out !== 8'h10 || carry_out !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b first sum=%h c=%b want 10 0", sum_out, carry_out);
                    end
                    start = 1'b1; a_in = 8'h20; b_in = 8'h03;
                end else if (second < 0) begin
                    second = i;
                    checks++;
                    if (sum_out !== 8'h23 || carry_out !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b second sum=%h c=%b want 23 0", sum_out, carry_out);
                    end
                end
            end
            if (i == 13) begin
                checks++;
                if (sum_out !== 8'h10 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b hold sum=%h busy=%b want 10 1", sum_out, busy);
                end
            end
        end
        checks++;
        if (first != 9 || second - first != 9) begin
            errors++;
            $display("FAIL b2b spacing first=%0d second=%0d want 9 18", first, second);
        end
    endtask

    task automatic test_async_reset();
        int bad = 0;
        @(negedge clk);
        start = 1'b1; a_in = 8'h35; b_in = 8'h4A;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 8'h00 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset immediate busy=%b done=%b sum=%h c=%b want all 0",
                     busy, done, sum_out, carry_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || sum_out !== 8'h00 || carry_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL async_reset after bad_cycles=%0d want 0", bad);
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        sub = 1'b1;
        run_op(8'h10, 8'h01, 8'h0F, 1'b1, "sub_10_01");
        run_op(8'h01, 8'h02, 8'hFF, 1'b0, "sub_01_02");
        sub = 1'b0;
        run_op(8'h35, 8'h4A, 8'h7F, 1'b0, "sub0_add_35_4a");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_while_busy();
        test_back_to_back();
        test_async_reset();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        run_op(8'h12, 8'h34, 8'h46, 1'b0, "add_after_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim_time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule
